// File: rtl/ser_pkg.sv
// Shared types and default geometry for the serializer controller.
// Build option: SERIALIZER_CTRL_PERF_EN adds the tile/stall performance counters.
package ser_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } ser_state_e;

  localparam int unsigned PoxDefault       = 3;
  localparam int unsigned PoyDefault       = 3;
  localparam int unsigned AddrWDefault     = 12;
  localparam int unsigned RowStrideDefault = 3;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serializer_ctrl_if.sv
// Tile-in / row-out bus of the serializer controller; master is the controller.
// Build option: SERIALIZER_CTRL_PERF_EN adds perf_tiles / perf_stall.
interface serializer_ctrl_if #(
  parameter int unsigned ADDR_W = ser_pkg::AddrWDefault
);
  logic              tile_done;
  logic [ADDR_W-1:0] tile_base_addr;
  logic              wr_ready;
  logic              mac_output_valid;
  logic              serializer_out_signal;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;
  logic              mac_hold;
  logic              busy;
  logic              err_overflow;
`ifdef SERIALIZER_CTRL_PERF_EN
  logic [31:0]       perf_tiles;
  logic [31:0]       perf_stall;
`endif

  modport master (
    input  tile_done, tile_base_addr, wr_ready,
    output mac_output_valid, serializer_out_signal, wr_valid, wr_addr, wr_last,
           mac_hold, busy, err_overflow
`ifdef SERIALIZER_CTRL_PERF_EN
    , output perf_tiles, perf_stall
`endif
  );

  modport slave (
    output tile_done, tile_base_addr, wr_ready,
    input  mac_output_valid, serializer_out_signal, wr_valid, wr_addr, wr_last,
           mac_hold, busy, err_overflow
`ifdef SERIALIZER_CTRL_PERF_EN
    , input perf_tiles, perf_stall
`endif
  );

endinterface

// File: rtl/ser_addr_gen.sv
// Row write-address generator: latches a tile base and steps by ROW_STRIDE per shift,
// wrapping modulo 2**ADDR_W.
module ser_addr_gen
  import ser_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned ROW_STRIDE = RowStrideDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_shift,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] Stride = ADDR_W'(ROW_STRIDE);

  logic [ADDR_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_addr;

  // r_acc always holds base + row*stride for the row about to be shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_acc  <= i_base;
    end else if (i_shift) begin
      r_addr <= r_acc;
      r_acc  <= r_acc + Stride;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/serializer_ctrl.sv
// Sequences MAC tile results through the row serializer and generates row write requests.
// Build option: SERIALIZER_CTRL_PERF_EN adds saturating perf_tiles / perf_stall counters.
module serializer_ctrl
  import ser_pkg::*;
#(
  parameter int unsigned POX        = PoxDefault,
  parameter int unsigned POY        = PoyDefault,
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned ROW_STRIDE = RowStrideDefault
) (
  input logic               clk,
  input logic               rst,
  serializer_ctrl_if.master bus
);

  localparam int unsigned     RowW    = clog2_min1(POY);
  localparam logic [RowW-1:0] LastRow = RowW'(POY - 1);

  if (POX == 0 || POY == 0) begin : g_bad_cfg
    $error("serializer_ctrl: POX and POY must be nonzero");
  end

  ser_state_e        r_state;
  logic [RowW-1:0]   r_row;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [ADDR_W-1:0] r_load_base;
  logic              r_wr_valid;
  logic              r_wr_last;
  logic              r_err_overflow;

  logic              w_shift;
  logic              w_last_shift;
  logic              w_take_pend;
  logic              w_take_new;
  logic              w_pend_store;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_shift      = (r_state == StShift) && bus.wr_ready;
  assign w_last_shift = w_shift && (r_row == LastRow);
  assign w_take_pend  = r_pend_valid && ((r_state == StIdle) || w_last_shift);
  assign w_take_new   = (r_state == StIdle) && bus.tile_done && !r_pend_valid;
  // Any tile_done not started directly from IDLE goes through the pending slot.
  assign w_pend_store = bus.tile_done && !w_take_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_row          <= '0;
      r_pend_valid   <= 1'b0;
      r_pend_addr    <= '0;
      r_load_base    <= '0;
      r_wr_valid     <= 1'b0;
      r_wr_last      <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_wr_valid <= w_shift;
      r_wr_last  <= w_last_shift;

      unique case (r_state)
        StIdle: begin
          if (w_take_pend) begin
            r_state     <= StLoad;
            r_load_base <= r_pend_addr;
          end else if (w_take_new) begin
            r_state     <= StLoad;
            r_load_base <= bus.tile_base_addr;
          end
        end
        StLoad: begin
          r_row   <= '0;
          r_state <= StShift;
        end
        StShift: begin
          if (w_last_shift) begin
            r_row <= '0;
            if (r_pend_valid) begin
              r_state     <= StLoad;
              r_load_base <= r_pend_addr;
            end else begin
              r_state <= StIdle;
            end
          end else if (w_shift) begin
            r_row <= r_row + RowW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_pend_store) begin
        if (!r_pend_valid || w_take_pend) begin
          r_pend_valid <= 1'b1;
          r_pend_addr  <= bus.tile_base_addr;
        end else begin
          r_err_overflow <= 1'b1;
        end
      end else if (w_take_pend) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  ser_addr_gen #(
    .ADDR_W    (ADDR_W),
    .ROW_STRIDE(ROW_STRIDE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == StLoad),
    .i_base (r_load_base),
    .i_shift(w_shift),
    .o_addr (w_wr_addr)
  );

  assign bus.mac_output_valid      = (r_state == StLoad);
  assign bus.serializer_out_signal = w_shift;
  assign bus.wr_valid              = r_wr_valid;
  assign bus.wr_addr               = w_wr_addr;
  assign bus.wr_last               = r_wr_last;
  assign bus.mac_hold              = r_pend_valid;
  assign bus.busy                  = (r_state != StIdle);
  assign bus.err_overflow          = r_err_overflow;

`ifdef SERIALIZER_CTRL_PERF_EN
  logic [31:0] r_perf_tiles;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_tiles <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_last_shift && (r_perf_tiles != '1)) begin
        r_perf_tiles <= r_perf_tiles + 32'd1;
      end
      if ((r_state == StShift) && !bus.wr_ready && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign bus.perf_tiles = r_perf_tiles;
  assign bus.perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_serializer_ctrl.sv
// Directed self-checking bench for serializer_ctrl (POY=3, ADDR_W=12, ROW_STRIDE=3).
// Perf counter checks are included when SERIALIZER_CTRL_PERF_EN is defined.
module tb_serializer_ctrl;
  import ser_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serializer_ctrl_if #(.ADDR_W(12)) bus ();

  serializer_ctrl #(
    .POX       (3),
    .POY       (3),
    .ADDR_W    (12),
    .ROW_STRIDE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge, where inputs change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drives tile_done for one cycle; returns in the following (LOAD) cycle.
  task automatic start_tile(input logic [11:0] base);
    bus.tile_done      = 1'b1;
    bus.tile_base_addr = base;
    step();
    bus.tile_done      = 1'b0;
    settle();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mov"},  32'(bus.mac_output_valid),      32'd0);
    chk({tag, "_sos"},  32'(bus.serializer_out_signal), 32'd0);
    chk({tag, "_wrv"},  32'(bus.wr_valid),              32'd0);
    chk({tag, "_last"}, 32'(bus.wr_last),               32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),                  32'd0);
    chk({tag, "_hold"}, 32'(bus.mac_hold),              32'd0);
  endtask

  task automatic chk_row(input string tag, input logic [11:0] addr, input logic last);
    chk({tag, "_wrv"},  32'(bus.wr_valid), 32'd1);
    chk({tag, "_addr"}, 32'(bus.wr_addr),  32'(addr));
    chk({tag, "_last"}, 32'(bus.wr_last),  32'(last));
  endtask

  logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int   n_shift;
  int   n_valid;
  int   n_load;
  int   n_bad;
  int   n_act;

  initial begin
    rst                = 1'b1;
    bus.tile_done      = 1'b0;
    bus.tile_base_addr = '0;
    bus.wr_ready       = 1'b0;
    step();
    step();
    chk_quiet("rst");
    chk("rst_err",  32'(bus.err_overflow), 32'd0);
    chk("rst_addr", 32'(bus.wr_addr),      32'd0);
    rst = 1'b0;
    settle();
    chk_quiet("rel0");
    step();
    chk_quiet("rel1");

    // Single tile, wr_ready high: rows at tile_done+3..+5, idle at +5.
    bus.wr_ready = 1'b1;
    start_tile(12'h010);
    chk("t1_load_mov",  32'(bus.mac_output_valid), 32'd1);
    chk("t1_load_busy", 32'(bus.busy),             32'd1);
    chk("t1_load_wrv",  32'(bus.wr_valid),         32'd0);
    step();
    chk("t1_c2_sos", 32'(bus.serializer_out_signal), 32'd1);
    chk("t1_c2_wrv", 32'(bus.wr_valid),              32'd0);
    step();
    chk_row("t1_r0", 12'h010, 1'b0);
    step();
    chk_row("t1_r1", 12'h013, 1'b0);
    step();
    chk_row("t1_r2", 12'h016, 1'b1);
    chk("t1_c5_busy", 32'(bus.busy), 32'd0);
    step();
    chk("t1_c6_wrv", 32'(bus.wr_valid), 32'd0);

    // wr_ready pattern 1,0,0,1,1 in SHIFT: three shifts, two stall cycles.
    bus.wr_ready = 1'b0;
    start_tile(12'h020);
    n_shift = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      bus.wr_ready = pat[i];
      settle();
      if (bus.serializer_out_signal) n_shift++;
    end
    chk("t2_shifts", 32'(n_shift), 32'd3);
    chk_row("t2_r1", 12'h023, 1'b0);
    step();
    chk_row("t2_r2", 12'h026, 1'b1);
    chk("t2_busy", 32'(bus.busy), 32'd0);
`ifdef SERIALIZER_CTRL_PERF_EN
    chk("t2_perf_stall", bus.perf_stall, 32'd2);
    chk("t2_perf_tiles", bus.perf_tiles, 32'd2);
`endif

    // Second tile_done during SHIFT: held as pending, LOAD right after last shift.
    bus.wr_ready = 1'b1;
    start_tile(12'h100);
    step();
    step();
    bus.tile_done      = 1'b1;
    bus.tile_base_addr = 12'h200;
    settle();
    chk("t3_c3_hold", 32'(bus.mac_hold), 32'd0);
    chk_row("t3_a0", 12'h100, 1'b0);
    step();
    bus.tile_done = 1'b0;
    chk("t3_c4_hold", 32'(bus.mac_hold), 32'd1);
    chk_row("t3_a1", 12'h103, 1'b0);
    step();
    chk("t3_c5_mov",  32'(bus.mac_output_valid), 32'd1);
    chk("t3_c5_hold", 32'(bus.mac_hold),         32'd0);
    chk_row("t3_a2", 12'h106, 1'b1);
    step();
    chk("t3_c6_wrv", 32'(bus.wr_valid),              32'd0);
    chk("t3_c6_sos", 32'(bus.serializer_out_signal), 32'd1);
    step();
    chk_row("t3_b0", 12'h200, 1'b0);
    step();
    chk_row("t3_b1", 12'h203, 1'b0);
    step();
    chk_row("t3_b2", 12'h206, 1'b1);
    chk("t3_c9_busy", 32'(bus.busy), 32'd0);

    // Third tile_done with pending full is dropped and flags overflow.
    start_tile(12'h300);
    n_valid = 0;
    n_load  = 0;
    n_bad   = 0;
    for (int c = 2; c < 16; c++) begin
      step();
      bus.tile_done      = (c == 2) || (c == 3);
      bus.tile_base_addr = (c == 2) ? 12'h400 : 12'h500;
      settle();
      if (bus.wr_valid) n_valid++;
      if (bus.mac_output_valid) n_load++;
      if (bus.wr_valid && (bus.wr_addr >= 12'h500)) n_bad++;
    end
    chk("t4_err",    32'(bus.err_overflow), 32'd1);
    chk("t4_rows",   32'(n_valid),          32'd6);
    chk("t4_loads",  32'(n_load),           32'd1);
    chk("t4_dropped_rows", 32'(n_bad),      32'd0);
    chk("t4_last_addr", 32'(bus.wr_addr),   32'h406);
    chk("t4_hold",   32'(bus.mac_hold),     32'd0);
    step();
    chk("t4_err_sticky", 32'(bus.err_overflow), 32'd1);

    // Reset in SHIFT at row 1 discards the tile and clears the sticky flag.
    start_tile(12'h040);
    step();
    step();
    chk("t5_pre_sos", 32'(bus.serializer_out_signal), 32'd1);
    rst = 1'b1;
    step();
    chk_quiet("t5_rst");
    chk("t5_rst_err",  32'(bus.err_overflow), 32'd0);
    chk("t5_rst_addr", 32'(bus.wr_addr),      32'd0);
    rst = 1'b0;
    n_act = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.wr_valid || bus.busy || bus.mac_output_valid) n_act++;
    end
    chk("t5_no_activity", 32'(n_act), 32'd0);
    start_tile(12'h050);
    step();
    step();
    chk_row("t5_new_r0", 12'h050, 1'b0);
    step();
    step();
    step();

    // Address wrap at the top of the 12-bit space.
    start_tile(12'hFFE);
    step();
    step();
    chk_row("t6_r0", 12'hFFE, 1'b0);
    step();
    chk_row("t6_r1", 12'h001, 1'b0);
    step();
    chk_row("t6_r2", 12'h004, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
